// File: rtl/disp_scan_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_tx_if
// Brief    : Digit write port from the core into the display scan generator.
// Revision : 1.0 - initial release
// ============================================================================
interface disp_scan_tx_if;
    logic       wr_en_i;
    logic [1:0] wr_addr_i;
    logic       wr_raw_i;
    logic [7:0] wr_data_i;

    modport master (
        output wr_en_i,
        output wr_addr_i,
        output wr_raw_i,
        output wr_data_i
    );

    modport slave (
        input  wr_en_i,
        input  wr_addr_i,
        input  wr_raw_i,
        input  wr_data_i
    );
endinterface
`default_nettype wire

// File: rtl/disp_scan_tx.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_tx
// Brief    : Four-digit seven-segment scan generator with double-buffered,
//            hex-encoding digit registers and inter-digit blanking.
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_tx #(
    parameter int BLANK_CYC = 16,
    parameter int SHOW_CYC  = 50000,
    parameter int CNT_W     = 16
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        en_i,
    disp_scan_tx_if.slave    wr,
    output logic [7:0]       seg_o,
    output logic [7:0]       sel_o,
    output logic             frame_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [7:0]       SEL_NONE   = 8'hFF;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shadow_q [4];
    logic [7:0]       shadow_d [4];
    logic [7:0]       active_q [4];
    logic [7:0]       active_d [4];
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       sel_q, sel_d;
    logic             frame_q, frame_d;
    logic             commit;

    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'h3F;  4'h1: s = 8'h06;  4'h2: s = 8'h5B;  4'h3: s = 8'h4F;
            4'h4: s = 8'h66;  4'h5: s = 8'h6D;  4'h6: s = 8'h7D;  4'h7: s = 8'h07;
            4'h8: s = 8'h7F;  4'h9: s = 8'h6F;  4'hA: s = 8'h77;  4'hB: s = 8'h7C;
            4'hC: s = 8'h39;  4'hD: s = 8'h5E;  4'hE: s = 8'h79;  default: s = 8'h71;
        endcase
        return s;
    endfunction

    // Select codes follow the demultiplexer: digit 0 drives bit 3 low, digit 3 bit 0.
    function automatic logic [7:0] sel_code(input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = 8'b1111_0111;
            2'd1:    c = 8'b1111_1011;
            2'd2:    c = 8'b1111_1101;
            default: c = 8'b1111_1110;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        frame_d  = 1'b0;
        commit   = 1'b0;
        seg_d    = 8'h00;
        sel_d    = SEL_NONE;

        if (wr.wr_en_i) begin
            shadow_d[wr.wr_addr_i] = wr.wr_raw_i ? wr.wr_data_i
                                   : (hex_seg(wr.wr_data_i[3:0]) | {wr.wr_data_i[7], 7'b0});
        end

        if (!en_i) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (idx_q == 2'd3) begin
                            idx_d   = 2'd0;
                            frame_d = 1'b1;
                            commit  = 1'b1;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Commit reads the pre-write shadow so a colliding write lands one frame later.
        if (commit) begin
            active_d = shadow_q;
        end

        if (state_d == ST_SHOW) begin
            sel_d = sel_code(idx_d);
            seg_d = active_d[idx_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            shadow_q <= '{default: 8'h00};
            active_q <= '{default: 8'h00};
            seg_q    <= 8'h00;
            sel_q    <= SEL_NONE;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
            frame_q  <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign sel_o   = sel_q;
    assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_tx
// Brief    : Directed bench for disp_scan_tx with BLANK_CYC=2, SHOW_CYC=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan_tx;

    localparam int BC = 2;
    localparam int SC = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic [7:0] seg_o;
    logic [7:0] sel_o;
    logic       frame_o;

    int errors = 0;
    int checks = 0;

    disp_scan_tx_if u_if ();

    disp_scan_tx #(
        .BLANK_CYC (BC),
        .SHOW_CYC  (SC),
        .CNT_W     (16)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .wr      (u_if),
        .seg_o   (seg_o),
        .sel_o   (sel_o),
        .frame_o (frame_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic       en;
        logic       wr;
        logic [1:0] addr;
        logic       raw;
        logic [7:0] data;
        int         n;
        logic [7:0] sel;
        logic [7:0] seg;
        logic       frm;
    } vec_t;

    vec_t tbl [18];

    task automatic drive_wr(input logic [1:0] a, input logic raw, input logic [7:0] d);
        u_if.wr_en_i   = 1'b1;
        u_if.wr_addr_i = a;
        u_if.wr_raw_i  = raw;
        u_if.wr_data_i = d;
    endtask

    // One clock: any pending write is sampled at this edge, then dropped.
    task automatic step(input string nm, input logic [7:0] esel, input logic [7:0] eseg,
                        input logic efr);
        @(posedge clk_i);
        #1;
        u_if.wr_en_i = 1'b0;
        checks++;
        if (sel_o !== esel || seg_o !== eseg || frame_o !== efr) begin
            errors++;
            $display("FAIL %s @%0t: sel=%h seg=%h frame=%b, expected sel=%h seg=%h frame=%b",
                     nm, $time, sel_o, seg_o, frame_o, esel, eseg, efr);
        end
    endtask

    // Full frame check; optionally issues a hex write right after show cycle wcyc of digit wdig.
    task automatic frame_chk(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                             input logic [7:0] s3, input logic pf, input int wdig, input int wcyc,
                             input logic [1:0] wa, input logic [7:0] wdat);
        logic [7:0] segs  [4];
        logic [7:0] codes [4];
        segs[0] = s0;  segs[1] = s1;  segs[2] = s2;  segs[3] = s3;
        codes[0] = 8'hF7; codes[1] = 8'hFB; codes[2] = 8'hFD; codes[3] = 8'hFE;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < BC; c++)
                step($sformatf("blank%0d", d), 8'hFF, 8'h00, (d == 0 && c == 0) ? pf : 1'b0);
            for (int c = 0; c < SC; c++) begin
                step($sformatf("show%0d", d), codes[d], segs[d], 1'b0);
                if (d == wdig && c == wcyc) drive_wr(wa, 1'b0, wdat);
            end
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        en_i           = 1'b0;
        u_if.wr_en_i   = 1'b0;
        u_if.wr_addr_i = 2'd0;
        u_if.wr_raw_i  = 1'b0;
        u_if.wr_data_i = 8'h00;

        //            rst   en    wr    addr  raw   data   n  sel    seg    frm
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'h55, 3, 8'hFF, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 2, 8'hFF, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4, 8'hF7, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1, 8'hFF, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h01, 1, 8'hFF, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h02, 1, 8'hFF, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'h03, 1, 8'hFF, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 8'h04, 1, 8'hFF, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 2, 8'hFF, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4, 8'hF7, 8'h06, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 2, 8'hFF, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4, 8'hFB, 8'h5B, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 2, 8'hFF, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4, 8'hFD, 8'h4F, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 2, 8'hFF, 8'h00, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4, 8'hFE, 8'h66, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1, 8'hFF, 8'h00, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1, 8'hFF, 8'h00, 1'b0};

        // Reset with enable and write held, zero banks, hex scan order, frame pulse.
        for (int i = 0; i < 18; i++) begin
            rst_i = tbl[i].rst;
            en_i  = tbl[i].en;
            if (tbl[i].wr) drive_wr(tbl[i].addr, tbl[i].raw, tbl[i].data);
            else           u_if.wr_en_i = 1'b0;
            for (int k = 0; k < tbl[i].n; k++)
                step($sformatf("vec%0d", i), tbl[i].sel, tbl[i].seg, tbl[i].frm);
        end

        // Raw pattern and hex with dp.
        drive_wr(2'd2, 1'b1, 8'hAA);
        step("wr_raw", 8'hFF, 8'h00, 1'b0);
        drive_wr(2'd1, 1'b0, 8'h8F);
        step("wr_dp", 8'hFF, 8'h00, 1'b0);
        en_i = 1'b1;
        frame_chk(8'h06, 8'hF1, 8'hAA, 8'h66, 1'b0, -1, 0, 2'd0, 8'h00);

        // Mid-frame write must not tear the current frame.
        frame_chk(8'h06, 8'hF1, 8'hAA, 8'h66, 1'b1, 1, 1, 2'd0, 8'h08);
        frame_chk(8'h7F, 8'hF1, 8'hAA, 8'h66, 1'b1, -1, 0, 2'd0, 8'h00);

        // Write sampled on the commit edge shows up one frame late.
        frame_chk(8'h7F, 8'hF1, 8'hAA, 8'h66, 1'b1, 3, SC - 1, 2'd3, 8'h00);
        frame_chk(8'h7F, 8'hF1, 8'hAA, 8'h66, 1'b1, -1, 0, 2'd0, 8'h00);
        frame_chk(8'h7F, 8'hF1, 8'hAA, 8'h3F, 1'b1, -1, 0, 2'd0, 8'h00);

        // Enable drop during digit 2, then restart from digit 0.
        step("ab_blank", 8'hFF, 8'h00, 1'b1);
        step("ab_blank", 8'hFF, 8'h00, 1'b0);
        for (int c = 0; c < SC; c++) step("ab_show0", 8'hF7, 8'h7F, 1'b0);
        for (int c = 0; c < BC; c++) step("ab_blank", 8'hFF, 8'h00, 1'b0);
        for (int c = 0; c < SC; c++) step("ab_show1", 8'hFB, 8'hF1, 1'b0);
        for (int c = 0; c < BC; c++) step("ab_blank", 8'hFF, 8'h00, 1'b0);
        for (int c = 0; c < 2; c++)  step("ab_show2", 8'hFD, 8'hAA, 1'b0);
        en_i = 1'b0;
        for (int c = 0; c < 3; c++)  step("ab_drop", 8'hFF, 8'h00, 1'b0);
        en_i = 1'b1;
        frame_chk(8'h7F, 8'hF1, 8'hAA, 8'h3F, 1'b0, -1, 0, 2'd0, 8'h00);
        step("ab_end", 8'hFF, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
